// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Streams an instruction image into the CPU instruction memory and keeps the
// core in reset until the whole image is written plus a settle interval.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   reload      single-cycle pulse: abandon whatever is going on, restart at word 0
//   s_valid     source presents a word on s_data
//   s_ready     loader accepts a word this cycle (combinational)
//   s_data      instruction word
//   s_last      s_data is the final word of the image
//   imem_we     instruction memory write strobe (registered)
//   imem_addr   word index into instruction memory (registered)
//   imem_wdata  write data (registered)
//   cpu_rst     reset to the CPU, active high (registered)
//   done        image loaded and CPU released (registered)
//   error       memory filled without seeing s_last (registered)
//   word_count  words written in the current load (registered)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [3:0]        HOLD_INIT = 4'(HOLD_CYCLES);

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          hold_cnt_r;
    logic [3:0]          hold_cnt_next_s;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W:0]     word_count_r;
    logic                s_ready_s;
    logic                handshake_s;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                cpu_rst_r;
    logic                done_r;
    logic                error_r;

    // Accept logic: only LOAD takes words, and never in a reset or reload cycle.
    always_comb begin
        s_ready_s = 1'b0;
        if (rst) begin
            s_ready_s = 1'b0;
        end else if (reload) begin
            s_ready_s = 1'b0;
        end else if (state_r == ST_LOAD) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
        handshake_s = s_valid && s_ready_s;
    end

    // Next-state and hold-counter logic; reload overrides every state.
    always_comb begin
        state_next_s    = state_r;
        hold_cnt_next_s = hold_cnt_r;
        if (reload) begin
            state_next_s    = ST_LOAD;
            hold_cnt_next_s = 4'd0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    // s_last wins over overflow: a terminated full image is legal.
                    if (handshake_s && s_last) begin
                        state_next_s    = ST_HOLD;
                        hold_cnt_next_s = HOLD_INIT;
                    end else if (handshake_s && (wr_ptr_r == LAST_ADDR)) begin
                        state_next_s    = ST_ERROR;
                        hold_cnt_next_s = 4'd0;
                    end else begin
                        state_next_s    = ST_LOAD;
                        hold_cnt_next_s = hold_cnt_r;
                    end
                end
                ST_HOLD: begin
                    // The cycle that sees 1 is the last HOLD cycle; <= guards a zero count.
                    if (hold_cnt_r <= 4'd1) begin
                        state_next_s    = ST_RUN;
                        hold_cnt_next_s = 4'd0;
                    end else begin
                        state_next_s    = ST_HOLD;
                        hold_cnt_next_s = hold_cnt_r - 4'd1;
                    end
                end
                ST_RUN: begin
                    state_next_s    = ST_RUN;
                    hold_cnt_next_s = 4'd0;
                end
                ST_ERROR: begin
                    state_next_s    = ST_ERROR;
                    hold_cnt_next_s = 4'd0;
                end
                default: begin
                    state_next_s    = ST_LOAD;
                    hold_cnt_next_s = 4'd0;
                end
            endcase
        end
    end

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_next_s;
            hold_cnt_r <= hold_cnt_next_s;
        end
    end

    // Write port, pointer/count and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            wr_ptr_r     <= '0;
            word_count_r <= '0;
            cpu_rst_r    <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            imem_we_r <= handshake_s;
            if (handshake_s) begin
                imem_addr_r  <= wr_ptr_r;
                imem_wdata_r <= s_data;
            end else begin
                imem_addr_r  <= imem_addr_r;
                imem_wdata_r <= imem_wdata_r;
            end
            // reload and handshake never coincide because s_ready drops on reload.
            if (reload) begin
                wr_ptr_r     <= '0;
                word_count_r <= '0;
            end else if (handshake_s) begin
                wr_ptr_r     <= wr_ptr_r + ADDR_W'(1);
                word_count_r <= word_count_r + (ADDR_W + 1)'(1);
            end else begin
                wr_ptr_r     <= wr_ptr_r;
                word_count_r <= word_count_r;
            end
            // Status follows the state being entered so it lines up with the final write.
            cpu_rst_r <= (state_next_s != ST_RUN);
            done_r    <= (state_next_s == ST_RUN);
            error_r   <= (state_next_s == ST_ERROR);
        end
    end

    assign s_ready    = s_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

    imem_loader_checker u_checker (
        .clk     (clk),
        .rst     (rst),
        .s_ready (s_ready_s),
        .imem_we (imem_we_r),
        .cpu_rst (cpu_rst_r),
        .done    (done_r),
        .error   (error_r)
    );

endmodule

// -----------------------------------------------------------------------------
// imem_loader_checker
//
// Safety properties of the loader outputs: memory is never written while the
// CPU runs, and done/cpu_rst/error stay mutually consistent.
//
// Ports: clk, rst, and the loader's s_ready, imem_we, cpu_rst, done, error.
// -----------------------------------------------------------------------------
module imem_loader_checker (
    input logic clk,
    input logic rst,
    input logic s_ready,
    input logic imem_we,
    input logic cpu_rst,
    input logic done,
    input logic error
);

    a_no_write_while_running: assert property (
        @(posedge clk) disable iff (rst) imem_we |-> cpu_rst
    );

    a_done_is_release: assert property (
        @(posedge clk) disable iff (rst) done == !cpu_rst
    );

    a_done_error_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(done && error)
    );

    a_ready_only_in_reset: assert property (
        @(posedge clk) disable iff (rst) s_ready |-> (cpu_rst && !done && !error)
    );

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction words into the CPU's instruction memory and holds the core in reset until the image is complete. It sits between a word-stream source (bench driver, debug link, boot ROM streamer) and the `riscv_cpu` instruction-memory write port. It releases `cpu_rst` only after the last word is written plus a fixed settle interval. It is the writer side of the path the CPU's fetch stage reads from.

## Interface

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words
- ADDR_W, 8, word-address width; must satisfy 2^ADDR_W >= DEPTH_WORDS
- HOLD_CYCLES, 4, cycles `cpu_rst` stays high after the last write (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- reload  in  1  single-cycle pulse; abort the current state and restart loading at word 0
- s_valid  in  1  source has a word on `s_data`
- s_ready  out  1  loader accepts a word this cycle
- s_data  in  32  instruction word
- s_last  in  1  qualifies `s_data` as the final word of the image
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  word index, not a byte address; CPU pc[ADDR_W+1:2] maps to it
- imem_wdata  out  32  write data
- cpu_rst  out  1  reset to `riscv_cpu`, active high
- done  out  1  image loaded and CPU released
- error  out  1  image exceeded DEPTH_WORDS without `s_last`
- word_count  out  ADDR_W+1  words written in the current load

## Operation

- States: LOAD, HOLD, RUN, ERROR.
- `rst` sets the state to LOAD with these outputs: `cpu_rst`=1, `s_ready`=0 for the reset cycle, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `error`=0, `word_count`=0.
- LOAD:
  - `s_ready` = !reload.
  - A handshake is `s_valid && s_ready`.
  - Each handshake registers `imem_we`=1, `imem_addr`=wr_ptr and `imem_wdata`=s_data for exactly one cycle, then increments wr_ptr and `word_count`.
- Transitions out of LOAD:
  - Handshake with `s_last`=1 goes to HOLD and loads the hold counter with HOLD_CYCLES.
  - Handshake with `s_last`=0 when wr_ptr == DEPTH_WORDS-1 writes that word and then goes to ERROR. The memory is full without a terminator.
- HOLD:
  - `s_ready`=0 and `cpu_rst`=1.
  - The counter decrements each cycle. Reaching 0 goes to RUN.
- RUN: `cpu_rst`=0, `done`=1, `s_ready`=0. Stays here until `reload` or `rst`.
- ERROR:
  - `error`=1, `cpu_rst`=1, `s_ready`=0.
  - Words already written remain in memory.
  - Leaves only on `reload` or `rst`.
- `reload` in any state, evaluated the same cycle:
  - state becomes LOAD.
  - wr_ptr=0, `word_count`=0, `done`=0, `error`=0, `cpu_rst`=1 from the next cycle.
  - Any write strobe already registered still completes.
  - `s_ready` is 0 during the `reload` cycle, so a simultaneous `s_valid` is not accepted.
- A single-word image (first handshake carries `s_last`) is legal and gives `word_count`=1.
- `word_count` holds its final value in HOLD, RUN and ERROR.

## Timing

- Write latency: the handshake happens in cycle N. `imem_we`, `imem_addr` and `imem_wdata` are valid in cycle N+1, registered.
- Throughput: one word per cycle when `s_valid` is held high.
- Last-word sequence for a handshake in cycle N:
  - write strobe in cycle N+1.
  - HOLD occupies cycles N+1 .. N+HOLD_CYCLES.
  - `cpu_rst` falls and `done` rises together at the edge ending cycle N+HOLD_CYCLES. Both are first observed low/high in cycle N+HOLD_CYCLES+1.
- The last memory write always precedes `cpu_rst` deassertion by at least HOLD_CYCLES cycles.
- Overflow: the write of word DEPTH_WORDS-1 and `error`=1 appear in the same cycle, N+1.
- `rst` takes priority over `reload`. Both are sampled only on rising `clk`.

## Test plan

- Burst load: with HOLD_CYCLES=4, stream 0x00500093, 0x00308113, 0x002081B3 (last) back-to-back.
  - Expect writes to addr 0,1,2 in consecutive cycles.
  - Expect `word_count`=3.
  - Expect `cpu_rst` to drop and `done`=1 exactly 4 cycles after the third handshake cycle.
- Gapped source: toggle `s_valid` every other cycle for 5 words.
  - Expect exactly 5 strobes at addr 0..4 with matching data.
  - Expect no write in idle cycles.
- Overflow: with DEPTH_WORDS=8, send 8 words with `s_last`=0.
  - Expect 8 writes and `error`=1 alongside the write to addr 7.
  - Expect `s_ready`=0 afterwards, `cpu_rst` held at 1, and `done`=0.
- Reload mid-load: after 3 words, pulse `reload` with `s_valid`=1.
  - Expect that word is not accepted.
  - Expect `word_count`=0.
  - Expect the next accepted word to be written to addr 0.
- Reload from RUN: after `done`=1, pulse `reload`.
  - Expect `cpu_rst`=1 and `done`=0 the next cycle.
  - Expect a new 2-word image to load and release the CPU again.
- Reset mid-HOLD: assert `rst` during HOLD.
  - Expect all outputs at their reset values the next cycle, with `cpu_rst`=1.
  - Expect the load to restart at addr 0.
